jtag_tap_dreg_bank: RTL
=======================

Name: jtag_tap_dreg_bank

Overview:
- Parametrised JTAG TAP data-register bank with IDCODE, BYPASS and NUM_USER generic user data registers (UDRs) of width DR_WIDTH, plus the TDO mux.
- Each UDR captures parallel core data in Capture-DR, shifts in Shift-DR, and commits to a parallel update output in Update-DR.
- Each commit is length-checked: an Update-DR after a wrong shift count is suppressed and flagged.
- Sits between the TAP controller FSM and on-chip debug/config logic.

Parameters:
- IR_WIDTH, 8, instruction register width.
- DR_WIDTH, 16, width of every UDR (2..64).
- NUM_USER, 2, number of UDRs (1..8).
- IDCODE_VALUE, 32'h149511C3, IDCODE register capture value; bit 0 must be 1.
- IDCODE_OP, 8'h02, IDCODE opcode (IR_WIDTH bits).
- USER_OP_BASE, 8'h10, opcode of UDR 0. UDR i uses USER_OP_BASE+i. BYPASS is all ones. Every other opcode behaves as BYPASS.

Ports:
- tck  in  1  TAP clock; the only clock.
- trst  in  1  synchronous active-high reset, sampled on tck.
- tdi  in  1  serial input.
- state_test_logic_reset  in  1  TAP FSM state decode.
- state_capture_dr  in  1  TAP FSM state decode.
- state_shift_dr  in  1  TAP FSM state decode.
- state_update_dr  in  1  TAP FSM state decode.
- state_shift_ir  in  1  TAP FSM state decode.
- latched_ir  in  IR_WIDTH  current instruction.
- ir_tdo  in  1  serial output of the IR shift register.
- user_capture_data  in  NUM_USER*DR_WIDTH  parallel capture value; UDR i occupies slice [i*DR_WIDTH +: DR_WIDTH].
- user_select  out  NUM_USER  one-hot; UDR i opcode is active.
- user_update_data  out  NUM_USER*DR_WIDTH  committed UDR values.
- user_update_valid  out  NUM_USER  one-cycle commit pulse.
- user_len_err  out  NUM_USER  sticky length-error flags.
- tdo  out  1  serial output, changes on the falling edge of tck.
- tdo_en  out  1  output enable, changes on the falling edge of tck.

Behaviour:
- Reset and state actions: all sequential actions occur on the rising edge of tck unless stated otherwise. Priority per edge is trst > state_test_logic_reset > capture > shift > update.
- Reset values:
  - idcode shift register = IDCODE_VALUE; bypass = 0.
  - UDR shift registers = 0; bit counters = 0.
  - user_update_data = 0; user_update_valid = 0; user_len_err = 0.
  - tdo = 0 and tdo_en = 0, applied at the next falling edge while trst = 1.
- state_test_logic_reset resets everything listed under reset except user_update_data, which holds.
- user_select is combinational decode of latched_ir. At most one bit is set.
- IDCODE: Capture loads IDCODE_VALUE. Shift does {tdi, reg[31:1]}.
- BYPASS (selected for BYPASS and all unknown opcodes): Capture loads 0. Shift loads tdi.
- UDR i, when selected:
  - Capture: shift reg <= user_capture_data slice i; counter <= 0.
  - Shift: shift reg <= {tdi, reg[DR_WIDTH-1:1]}; counter increments and saturates at DR_WIDTH+1.
  - Update with counter == DR_WIDTH: user_update_data slice i <= shift reg; user_update_valid[i] = 1 for exactly the following cycle.
  - Update with counter != DR_WIDTH (including 0 shifts): update data holds, no valid pulse, user_len_err[i] <= 1.
  - user_len_err[i] clears only on trst or state_test_logic_reset.
- Unselected UDRs hold all state. An IR change between capture and update has no effect on a UDR that is no longer selected.
- user_update_valid is 0 in every cycle that does not immediately follow a qualifying update.
- TDO mux (combinational):
  - state_shift_ir: ir_tdo.
  - IDCODE selected: idcode[0].
  - UDR i selected: UDR i bit 0.
  - Otherwise: bypass bit.
- TDO timing: on the falling edge of tck, tdo <= mux output and tdo_en <= state_shift_dr | state_shift_ir.
- Latency: the first captured bit appears on tdo half a cycle after the capture edge.

Test Plan:
- Reset: trst high for 2 cycles -> tdo = 0, tdo_en = 0, all user_* outputs = 0. Then IDCODE: capture followed by 32 shifts with tdi = 0 -> tdo yields 0x149511C3, LSB first.
- BYPASS: IR = 8'hFF, capture, shift pattern 1,0,1,1 -> tdo yields 0,1,0,1,1 (one-cycle delay). Unknown opcode 8'h7E gives the same result.
- UDR 1 (IR = 8'h11): capture_data[1] = 16'hA5C3, capture, 16 shifts of 16'h1234 LSB first, update -> tdo yields A5C3 LSB first; user_update_data[1] = 16'h1234; user_update_valid = 2'b10 for one cycle only; UDR 0 unchanged.
- Length error: UDR 0 with 15 shifts then update -> no valid pulse, data holds, user_len_err[0] = 1. A following correct 16-shift update commits and the error flag stays 1. It clears after state_test_logic_reset.
- Zero-shift and overshoot: capture then immediate update -> error. 17 shifts then update -> error (counter saturates at 17).
- Mid-shift reset: trst during a UDR shift -> counter, shift register and flags = 0 next cycle. A subsequent update gives no commit; user_update_data is reset to 0.

Source files
------------

// File: rtl/jtag_tap_dreg_bank.sv
// jtag_tap_dreg_bank
//   Data-register bank behind a JTAG TAP controller: IDCODE, BYPASS and
//   NUM_USER user data registers (UDRs), plus the falling-edge TDO stage.
//   Every UDR commit is length-checked. An Update-DR that follows a wrong
//   number of Shift-DR cycles is dropped, and the UDR's sticky error flag
//   is set.
//
// Ports
//   tck                     TAP clock (only clock)
//   trst                    synchronous active-high reset, sampled on tck
//   tdi                     serial data in
//   state_*                 TAP FSM state decodes
//   latched_ir              current instruction
//   ir_tdo                  serial out of the IR shift register
//   user_capture_data       parallel capture values, UDR i at [i*DR_WIDTH +: DR_WIDTH]
//   user_select             one-hot UDR opcode decode
//   user_update_data        committed UDR values
//   user_update_valid       one-cycle commit pulse per UDR
//   user_len_err            sticky shift-length error per UDR
//   tdo, tdo_en             serial out and enable, updated on falling tck
module jtag_tap_dreg_bank #(
  parameter int                  IR_WIDTH     = 8,
  parameter int                  DR_WIDTH     = 16,
  parameter int                  NUM_USER     = 2,
  parameter logic [31:0]         IDCODE_VALUE = 32'h149511C3,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP    = 8'h02,
  parameter logic [IR_WIDTH-1:0] USER_OP_BASE = 8'h10
) (
  input  logic                         tck,
  input  logic                         trst,
  input  logic                         tdi,
  input  logic                         state_test_logic_reset,
  input  logic                         state_capture_dr,
  input  logic                         state_shift_dr,
  input  logic                         state_update_dr,
  input  logic                         state_shift_ir,
  input  logic [IR_WIDTH-1:0]          latched_ir,
  input  logic                         ir_tdo,
  input  logic [NUM_USER*DR_WIDTH-1:0] user_capture_data,
  output logic [NUM_USER-1:0]          user_select,
  output logic [NUM_USER*DR_WIDTH-1:0] user_update_data,
  output logic [NUM_USER-1:0]          user_update_valid,
  output logic [NUM_USER-1:0]          user_len_err,
  output logic                         tdo,
  output logic                         tdo_en
);

  // The counter must reach DR_WIDTH+1 so that an overshoot can be told
  // apart from an exact-length shift.
  localparam int                CNT_W    = $clog2(DR_WIDTH + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DR_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(DR_WIDTH + 1);

  logic [31:0]                  idcode_sr;
  logic                         bypass_sr;
  logic [DR_WIDTH-1:0]          udr_sr  [NUM_USER];
  logic [CNT_W-1:0]             bit_cnt [NUM_USER];
  logic [NUM_USER*DR_WIDTH-1:0] update_data_q;
  logic [NUM_USER-1:0]          update_valid_q;
  logic [NUM_USER-1:0]          len_err_q;

  logic                         idcode_sel;
  logic [NUM_USER-1:0]          user_sel;
  logic                         bypass_sel;
  logic                         tdo_mux;

  // Instruction decode. Anything that is neither IDCODE nor a UDR opcode
  // falls through to BYPASS.
  always_comb begin
    idcode_sel = (latched_ir == IDCODE_OP);
    user_sel   = '0;
    for (int i = 0; i < NUM_USER; i++) begin
      if (!idcode_sel && (latched_ir == IR_WIDTH'(USER_OP_BASE + IR_WIDTH'(i))))
        user_sel[i] = 1'b1;
    end
    bypass_sel = !idcode_sel && (user_sel == '0);
  end

  always_comb begin
    tdo_mux = bypass_sr;
    if (state_shift_ir) begin
      tdo_mux = ir_tdo;
    end else if (idcode_sel) begin
      tdo_mux = idcode_sr[0];
    end else begin
      for (int i = 0; i < NUM_USER; i++) begin
        if (user_sel[i]) tdo_mux = udr_sr[i][0];
      end
    end
  end

  always_ff @(posedge tck) begin
    if (trst) begin
      idcode_sr      <= IDCODE_VALUE;
      bypass_sr      <= 1'b0;
      update_data_q  <= '0;
      update_valid_q <= '0;
      len_err_q      <= '0;
      for (int i = 0; i < NUM_USER; i++) begin
        udr_sr[i]  <= '0;
        bit_cnt[i] <= '0;
      end
    end else if (state_test_logic_reset) begin
      // Same as trst, but committed data survives.
      idcode_sr      <= IDCODE_VALUE;
      bypass_sr      <= 1'b0;
      update_valid_q <= '0;
      len_err_q      <= '0;
      for (int i = 0; i < NUM_USER; i++) begin
        udr_sr[i]  <= '0;
        bit_cnt[i] <= '0;
      end
    end else begin
      update_valid_q <= '0;
      if (state_capture_dr) begin
        if (idcode_sel) idcode_sr <= IDCODE_VALUE;
        if (bypass_sel) bypass_sr <= 1'b0;
        for (int i = 0; i < NUM_USER; i++) begin
          if (user_sel[i]) begin
            udr_sr[i]  <= user_capture_data[i*DR_WIDTH +: DR_WIDTH];
            bit_cnt[i] <= '0;
          end
        end
      end else if (state_shift_dr) begin
        if (idcode_sel) idcode_sr <= {tdi, idcode_sr[31:1]};
        if (bypass_sel) bypass_sr <= tdi;
        for (int i = 0; i < NUM_USER; i++) begin
          if (user_sel[i]) begin
            udr_sr[i] <= {tdi, udr_sr[i][DR_WIDTH-1:1]};
            if (bit_cnt[i] != CNT_SAT) bit_cnt[i] <= bit_cnt[i] + CNT_W'(1);
          end
        end
      end else if (state_update_dr) begin
        for (int i = 0; i < NUM_USER; i++) begin
          if (user_sel[i]) begin
            if (bit_cnt[i] == CNT_FULL) begin
              update_data_q[i*DR_WIDTH +: DR_WIDTH] <= udr_sr[i];
              update_valid_q[i]                     <= 1'b1;
            end else begin
              len_err_q[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  // TDO changes on the falling edge so the host samples a stable bit on
  // the next rising edge.
  always_ff @(negedge tck) begin
    if (trst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo    <= tdo_mux;
      tdo_en <= state_shift_dr | state_shift_ir;
    end
  end

  assign user_select       = user_sel;
  assign user_update_data  = update_data_q;
  assign user_update_valid = update_valid_q;
  assign user_len_err      = len_err_q;

endmodule
